fx2_packet_source: RTL and testbench

//  Supply side of the FX2 packet handshake: buffers 16-bit samples from the

---
 rtl/fx2_packet_source_if.sv | 24 ++
 rtl/fx2_packet_source.sv | 96 +++++++++
 tb/tb_fx2_packet_source.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fx2_packet_source_if.sv
// Handshake bundle between the acquisition side, the FX2 slave FIFO and
// fx2_packet_source. The master modport drives samples and FX2 requests.
interface fx2_packet_source_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  wr_en;
  logic [15:0]           wr_data;
  logic                  fx2_req;
  logic                  packet_rdy;
  logic [15:0]           dout;
  logic                  dout_valid;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, fx2_req,
    input  packet_rdy, dout, dout_valid, level, overflow
  );

  modport slave (
    input  wr_en, wr_data, fx2_req,
    output packet_rdy, dout, dout_valid, level, overflow
  );
endinterface

// File: rtl/fx2_packet_source.sv
// Circular sample buffer that releases exactly one PKT_WORDS packet per FX2 request burst.
// Optional macro FX2_SRC_DROP_CNT_EN adds a saturating drop_count output.
module fx2_packet_source #(
  parameter int DEPTH_LOG2 = 10,
  parameter int PKT_WORDS  = 256
) (
  input  logic               clk,
  input  logic               reset,
  fx2_packet_source_if.slave bus
`ifdef FX2_SRC_DROP_CNT_EN
  ,output logic [15:0]       drop_count
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PKT_LEVEL = (DEPTH_LOG2+1)'(PKT_WORDS);
  localparam logic [DEPTH_LOG2:0] LAST_CNT  = (DEPTH_LOG2+1)'(PKT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SEND, DONE} state_t;

  state_t              state, state_next;
  logic [15:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, word_cnt, level;
  logic                full, wr_ok, rd, rdy_next, last_word;

  // The extra pointer bit distinguishes a full buffer from an empty one.
  assign level     = wr_ptr - rd_ptr;
  assign full      = level[DEPTH_LOG2];
  assign wr_ok     = bus.wr_en && !full;
  assign last_word = (word_cnt == LAST_CNT);
  assign bus.level = level;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (level >= PKT_LEVEL) state_next = ARMED;
      ARMED:   if (bus.fx2_req) state_next = (PKT_WORDS == 1) ? DONE : SEND;
      SEND:    if (rd && last_word) state_next = DONE;
      DONE:    if (!bus.fx2_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // DONE swallows the tail of an FX2 request burst without reading.
  always_comb begin
    rd       = 1'b0;
    rdy_next = 1'b0;
    case (state)
      ARMED: begin
        rd       = bus.fx2_req;
        rdy_next = !bus.fx2_req;
      end
      SEND:    rd = bus.fx2_req;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      word_cnt       <= '0;
      bus.dout       <= 16'd0;
      bus.dout_valid <= 1'b0;
      bus.packet_rdy <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.packet_rdy <= rdy_next;
      bus.dout_valid <= rd;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (bus.wr_en && full) bus.overflow <= 1'b1;
      if (rd) begin
        bus.dout <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end
    end
  end

`ifdef FX2_SRC_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      drop_count <= 16'd0;
    else if (bus.wr_en && full && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fx2_packet_source.sv
// Directed bench for fx2_packet_source: a cycle table around the first packet
// plus hand sequences for pause, overflow, continuous writes and mid-packet reset.
module tb_fx2_packet_source;
  logic clk;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  logic [15:0] got[$];

  fx2_packet_source_if #(.DEPTH_LOG2(10)) bus ();

`ifdef FX2_SRC_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  fx2_packet_source #(.DEPTH_LOG2(10), .PKT_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FX2_SRC_DROP_CNT_EN
    ,.drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every delivered packet word on the falling edge.
  always @(negedge clk) begin
    if (!reset && bus.dout_valid === 1'b1) got.push_back(bus.dout);
  end

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_data;
    logic        fx2_req;
    logic        exp_rdy;
    logic        exp_valid;
    logic [15:0] exp_dout;
    logic [10:0] exp_level;
  } vec_t;

  vec_t vecs[8];

  task automatic applyStimulus(input logic w, input logic [15:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.fx2_req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    else passes++;
  endtask

  task automatic checkSeq(input string name, input int count);
    int errs = 0;
    checkOutput({name, " count"}, got.size(), count);
    for (int i = 0; i < count && i < got.size(); i++)
      if (got[i] !== 16'(i)) errs++;
    checkOutput({name, " order errors"}, errs, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0);
    reset = 1'b0;
    got.delete();
  endtask

  task automatic writeWords(input int first, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 16'(first + i), 1'b0);
  endtask

  task automatic holdReq(input logic r, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0, r);
  endtask

  initial begin
    int rdy_seen;
    int bad;

    vecs[0] = '{1'b1, 16'd254, 1'b0, 1'b0, 1'b0, 16'd0, 11'd255};
    vecs[1] = '{1'b1, 16'd255, 1'b0, 1'b0, 1'b0, 16'd0, 11'd256};
    vecs[2] = '{1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd0, 11'd256};
    vecs[3] = '{1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 16'd0, 11'd256};
    vecs[4] = '{1'b0, 16'd0,   1'b1, 1'b0, 1'b1, 16'd0, 11'd255};
    vecs[5] = '{1'b0, 16'd0,   1'b1, 1'b0, 1'b1, 16'd1, 11'd254};
    vecs[6] = '{1'b0, 16'd0,   1'b0, 1'b0, 1'b0, 16'd1, 11'd254};
    vecs[7] = '{1'b0, 16'd0,   1'b1, 1'b0, 1'b1, 16'd2, 11'd253};

    bus.wr_en = 1'b0; bus.wr_data = 16'd0; bus.fx2_req = 1'b0;

    // Reset state and the first packet, table-driven around arming.
    doReset();
    checkOutput("reset packet_rdy", bus.packet_rdy, 0);
    checkOutput("reset dout", bus.dout, 0);
    checkOutput("reset dout_valid", bus.dout_valid, 0);
    checkOutput("reset level", bus.level, 0);
    checkOutput("reset overflow", bus.overflow, 0);
`ifdef FX2_SRC_DROP_CNT_EN
    checkOutput("reset drop_count", drop_count, 0);
`endif
    writeWords(0, 254);
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].wr_en, vecs[v].wr_data, vecs[v].fx2_req);
      checkOutput($sformatf("vec%0d packet_rdy", v), bus.packet_rdy, vecs[v].exp_rdy);
      checkOutput($sformatf("vec%0d dout_valid", v), bus.dout_valid, vecs[v].exp_valid);
      checkOutput($sformatf("vec%0d dout", v), bus.dout, vecs[v].exp_dout);
      checkOutput($sformatf("vec%0d level", v), bus.level, vecs[v].exp_level);
    end
    holdReq(1'b1, 258);
    holdReq(1'b0, 1);
    checkSeq("pkt1", 256);
    checkOutput("pkt1 final level", bus.level, 0);
    checkOutput("pkt1 final packet_rdy", bus.packet_rdy, 0);
    checkOutput("pkt1 dout hold", bus.dout, 255);

    // 300 words: one packet per burst, 44 words left unarmed.
    doReset();
    writeWords(0, 300);
    holdReq(1'b0, 2);
    holdReq(1'b1, 300);
    holdReq(1'b0, 2);
    rdy_seen = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 16'd0, 1'b1);
      if (bus.packet_rdy) rdy_seen++;
    end
    holdReq(1'b0, 1);
    checkSeq("burst2", 256);
    checkOutput("burst2 level", bus.level, 44);
    checkOutput("burst2 packet_rdy highs", rdy_seen, 0);

    // Request pause after word 100.
    doReset();
    writeWords(0, 256);
    holdReq(1'b0, 2);
    holdReq(1'b1, 100);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 16'd0, 1'b0);
      if (bus.dout_valid !== 1'b0) bad++;
    end
    checkOutput("pause valid in gap", bad, 0);
    checkOutput("pause words before gap", got.size(), 100);
    holdReq(1'b1, 200);
    holdReq(1'b0, 1);
    checkSeq("pause", 256);

    // Overflow: 1030 writes into a 1024-word buffer.
    doReset();
    writeWords(0, 1030);
    checkOutput("ovf level", bus.level, 1024);
    checkOutput("ovf flag", bus.overflow, 1);
`ifdef FX2_SRC_DROP_CNT_EN
    checkOutput("ovf drop_count", drop_count, 6);
`endif
    holdReq(1'b1, 260);
    holdReq(1'b0, 1);
    checkSeq("ovf packet", 256);
    checkOutput("ovf level after", bus.level, 768);
    checkOutput("ovf flag sticky", bus.overflow, 1);

    // Continuous writes while streaming.
    doReset();
    writeWords(0, 258);
    checkOutput("cont packet_rdy", bus.packet_rdy, 1);
    checkOutput("cont level armed", bus.level, 258);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 16'(258 + i), 1'b1);
      if (bus.level !== 11'd258) bad++;
    end
    checkOutput("cont level steady", bad, 0);
    applyStimulus(1'b1, 16'd514, 1'b1);
    applyStimulus(1'b1, 16'd515, 1'b1);
    checkOutput("cont level done", bus.level, 260);
    rdy_seen = 0;
    for (int i = 0; i < 6 && rdy_seen == 0; i++) begin
      applyStimulus(1'b1, 16'(516 + i), 1'b0);
      if (bus.packet_rdy) rdy_seen = 1;
    end
    checkOutput("cont second packet_rdy", rdy_seen, 1);
    holdReq(1'b1, 2);
    holdReq(1'b0, 1);
    checkSeq("cont", 258);

    // Reset at word 128 of a packet.
    doReset();
    writeWords(0, 256);
    holdReq(1'b0, 2);
    holdReq(1'b1, 128);
    checkOutput("mid level", bus.level, 128);
    reset = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("mid reset packet_rdy", bus.packet_rdy, 0);
    checkOutput("mid reset dout", bus.dout, 0);
    checkOutput("mid reset dout_valid", bus.dout_valid, 0);
    checkOutput("mid reset level", bus.level, 0);
    checkOutput("mid reset overflow", bus.overflow, 0);
    reset = 1'b0;
    got.delete();
    holdReq(1'b1, 3);
    holdReq(1'b0, 2);
    checkOutput("mid after packet_rdy", bus.packet_rdy, 0);
    checkOutput("mid after words", got.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
